multiproc_ctrl_bridge: RTL and testbench

//   Parametrised request router between the host debug path (JTAG user-register requests,

---
 rtl/multiproc_ctrl_bridge.sv | 169 ++++++++++++++++
 tb/tb_multiproc_ctrl_bridge.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiproc_ctrl_bridge.sv
// Request router from the host debug path to NUM_ELEM processing elements:
// a control space (per-element reset / sleep) and a per-element memory bus with ack timeout.
module multiproc_ctrl_bridge #(
  parameter int NUM_ELEM       = 6,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ELEM_SHIFT     = 24,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           resetb,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_data,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           resp_err,
  output logic [NUM_ELEM-1:0]            elem_en,
  output logic                           elem_we,
  output logic [ELEM_SHIFT-1:0]          elem_addr,
  output logic [DATA_WIDTH-1:0]          elem_wdata,
  input  logic [NUM_ELEM-1:0]            elem_ack,
  input  logic [NUM_ELEM*DATA_WIDTH-1:0] elem_rdata,
  output logic [NUM_ELEM-1:0]            elem_reset,
  input  logic [NUM_ELEM-1:0]            elem_sleep
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   resp_data_reg, resp_data_next;
  logic                    resp_err_reg, resp_err_next;
  logic [NUM_ELEM-1:0]     elem_en_reg, elem_en_next;
  logic                    elem_we_reg, elem_we_next;
  logic [ELEM_SHIFT-1:0]   elem_addr_reg, elem_addr_next;
  logic [DATA_WIDTH-1:0]   elem_wdata_reg, elem_wdata_next;
  logic [NUM_ELEM-1:0]     elem_reset_reg, elem_reset_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;

  logic                    is_ctrl;
  logic [31:0]             req_idx;
  logic [NUM_ELEM-1:0]     req_sel;
  logic                    idx_ok;
  logic                    sel_sleep, sel_reset;
  logic                    ack_hit;
  logic [DATA_WIDTH-1:0]   ack_rdata;

  // Decode to a one-hot select; an out-of-range index yields an all-zero select.
  assign is_ctrl = req_addr[ADDR_WIDTH-1];
  assign req_idx = is_ctrl ? 32'(req_addr[7:0]) : 32'(req_addr[ADDR_WIDTH-2:ELEM_SHIFT]);

  generate
    for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_sel
      assign req_sel[gi] = (req_idx == 32'(gi));
    end
  endgenerate

  assign idx_ok    = |req_sel;
  assign sel_sleep = |(req_sel & elem_sleep);
  assign sel_reset = |(req_sel & elem_reset_reg);
  assign ack_hit   = |(elem_ack & elem_en_reg);

  always_comb begin
    ack_rdata = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      if (elem_en_reg[i]) ack_rdata |= elem_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_next      = state_reg;
    resp_data_next  = resp_data_reg;
    resp_err_next   = resp_err_reg;
    elem_en_next    = elem_en_reg;
    elem_we_next    = elem_we_reg;
    elem_addr_next  = elem_addr_reg;
    elem_wdata_next = elem_wdata_reg;
    elem_reset_next = elem_reset_reg;
    cnt_next        = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (!idx_ok) begin
            resp_err_next  = 1'b1;
            resp_data_next = '0;
            state_next     = ST_RESP;
          end else if (is_ctrl) begin
            resp_err_next = 1'b0;
            if (req_we) begin
              elem_reset_next = (elem_reset_reg & ~req_sel) | (req_sel & {NUM_ELEM{req_data[0]}});
              resp_data_next  = '0;
            end else begin
              resp_data_next = DATA_WIDTH'({sel_sleep, sel_reset});
            end
            state_next = ST_RESP;
          end else begin
            elem_en_next    = req_sel;
            elem_we_next    = req_we;
            elem_addr_next  = req_addr[ELEM_SHIFT-1:0];
            elem_wdata_next = req_data;
            cnt_next        = '0;
            state_next      = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // An ack on the final counted cycle still wins over the timeout.
        if (ack_hit) begin
          elem_en_next   = '0;
          resp_err_next  = 1'b0;
          resp_data_next = elem_we_reg ? '0 : ack_rdata;
          state_next     = ST_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          elem_en_next   = '0;
          resp_err_next  = 1'b1;
          resp_data_next = '0;
          state_next     = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_reg      <= ST_IDLE;
      resp_data_reg  <= '0;
      resp_err_reg   <= 1'b0;
      elem_en_reg    <= '0;
      elem_we_reg    <= 1'b0;
      elem_addr_reg  <= '0;
      elem_wdata_reg <= '0;
      elem_reset_reg <= '1;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      resp_data_reg  <= resp_data_next;
      resp_err_reg   <= resp_err_next;
      elem_en_reg    <= elem_en_next;
      elem_we_reg    <= elem_we_next;
      elem_addr_reg  <= elem_addr_next;
      elem_wdata_reg <= elem_wdata_next;
      elem_reset_reg <= elem_reset_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_data  = resp_data_reg;
  assign resp_err   = resp_err_reg;
  assign elem_en    = elem_en_reg;
  assign elem_we    = elem_we_reg;
  assign elem_addr  = elem_addr_reg;
  assign elem_wdata = elem_wdata_reg;
  assign elem_reset = elem_reset_reg;

endmodule

// File: tb/tb_multiproc_ctrl_bridge.sv
// Scoreboard bench for multiproc_ctrl_bridge: element responder with its own memory,
// reference model of the request/response rules, and a decoupled response monitor.
module tb_multiproc_ctrl_bridge;
  localparam int NE = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ES = 24;
  localparam int TO = 256;

  logic              clk = 1'b0;
  logic              resetb = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DW-1:0]     req_data = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [DW-1:0]     resp_data;
  logic              resp_err;
  logic [NE-1:0]     elem_en;
  logic              elem_we;
  logic [ES-1:0]     elem_addr;
  logic [DW-1:0]     elem_wdata;
  logic [NE-1:0]     elem_ack;
  logic [NE*DW-1:0]  elem_rdata;
  logic [NE-1:0]     elem_reset;
  logic [NE-1:0]     elem_sleep = '0;

  multiproc_ctrl_bridge #(
    .NUM_ELEM(NE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ELEM_SHIFT(ES), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetb(resetb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .elem_en(elem_en), .elem_we(elem_we), .elem_addr(elem_addr), .elem_wdata(elem_wdata),
    .elem_ack(elem_ack), .elem_rdata(elem_rdata),
    .elem_reset(elem_reset), .elem_sleep(elem_sleep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            txn = 0;
  resp_t         sb_q[$];
  logic [NE-1:0] ref_reset = '1;
  logic [31:0]   ref_mem[int];
  logic [31:0]   dev_mem[int];
  logic [NE-1:0] no_ack_mask = '0;
  logic [NE-1:0] stray_ack = '0;
  logic [NE-1:0] resp_ack;
  bit            hold_rr = 1'b0;
  logic [NE-1:0] exp_bus_en = '0;
  logic          exp_bus_we = 1'b0;
  logic [ES-1:0] exp_bus_addr = '0;
  logic [DW-1:0] exp_bus_wdata = '0;

  assign elem_ack = resp_ack | stray_ack;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_pat(int key);
    return key ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int mkey(int idx, logic [ES-1:0] a);
    return (idx << 24) | int'(a);
  endfunction

  // Reference: what the requester must see for one request, and which element bus it opens.
  task automatic ref_model(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           output resp_t r, output logic [NE-1:0] bus_en);
    int idx;
    int key;
    bus_en = '0;
    r.data = '0;
    r.err  = 1'b0;
    if (addr[AW-1]) begin
      idx = int'(addr[7:0]);
      if (idx >= NE) r.err = 1'b1;
      else if (we) ref_reset[idx] = data[0];
      else r.data = {30'd0, elem_sleep[idx], ref_reset[idx]};
    end else begin
      idx = int'(addr[AW-2:ES]);
      if (idx >= NE) r.err = 1'b1;
      else begin
        bus_en[idx] = 1'b1;
        key = mkey(idx, addr[ES-1:0]);
        if (no_ack_mask[idx]) r.err = 1'b1;
        else if (we) ref_mem[key] = data;
        else r.data = ref_mem.exists(key) ? ref_mem[key] : init_pat(key);
      end
    end
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!req_ready && n < 2000);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_wait: got req_ready=%b want 1 within 2000 cycles", req_ready);
    end
    req_we = we; req_addr = addr; req_data = data; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_we = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (sb_q.size() == 0 && req_ready && !resp_valid) return;
      n++;
    end
    checks++; errors++;
    $display("FAIL idle_wait: got pending=%0d req_ready=%b want 0 and 1", sb_q.size(), req_ready);
  endtask

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    resp_t r;
    logic [NE-1:0] be;
    ref_model(we, addr, data, r, be);
    exp_bus_en = be; exp_bus_we = we; exp_bus_addr = addr[ES-1:0]; exp_bus_wdata = data;
    sb_q.push_back(r);
    issue(we, addr, data);
    wait_idle();
    checks++;
    if (elem_reset !== ref_reset) begin
      errors++;
      $display("FAIL elem_reset after addr %h: got %h want %h", addr, elem_reset, ref_reset);
    end
  endtask

  // Response monitor: pops the scoreboard on every completed response handshake.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (resetb === 1'b1 && resp_valid === 1'b1) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_resp: got req_ready=%b want 0", req_ready);
        end
        if (resp_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got data=%h err=%b want no response", resp_data, resp_err);
          end else begin
            r = sb_q.pop_front();
            txn++;
            if (resp_data !== r.data || resp_err !== r.err) begin
              errors++;
              $display("FAIL resp %0d: got data=%h err=%b want data=%h err=%b",
                       txn, resp_data, resp_err, r.data, r.err);
            end else begin
              $display("txn %0d: data=%h err=%b", txn, resp_data, resp_err);
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      resp_ready = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Element responder: checks each new bus cycle, acks after a random delay, sprinkles
  // acks from non-selected elements while the selected one is still busy.
  initial begin
    int idx = 0;
    int delay = 0;
    int other;
    int key;
    bit pend = 1'b0;
    resp_ack = '0;
    elem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      resp_ack = '0;
      if (elem_en === '0) begin
        pend = 1'b0;
      end else begin
        if (!pend) begin
          pend = 1'b1;
          delay = $urandom_range(0, 3);
          idx = 0;
          for (int i = 0; i < NE; i++) if (elem_en[i]) idx = i;
          checks++;
          if (elem_en !== exp_bus_en || elem_we !== exp_bus_we || elem_addr !== exp_bus_addr ||
              (exp_bus_we && elem_wdata !== exp_bus_wdata)) begin
            errors++;
            $display("FAIL bus_cycle: got en=%h we=%b addr=%h wdata=%h want en=%h we=%b addr=%h wdata=%h",
                     elem_en, elem_we, elem_addr, elem_wdata,
                     exp_bus_en, exp_bus_we, exp_bus_addr, exp_bus_wdata);
          end
        end
        if (!no_ack_mask[idx] && delay == 0) begin
          key = mkey(idx, elem_addr);
          if (elem_we) dev_mem[key] = elem_wdata;
          else elem_rdata[idx*DW +: DW] = dev_mem.exists(key) ? dev_mem[key] : init_pat(key);
          resp_ack[idx] = 1'b1;
        end else begin
          if (delay > 0) delay--;
          if ($urandom_range(0, 2) == 0) begin
            other = (idx + 1 + $urandom_range(0, NE - 2)) % NE;
            resp_ack[other] = 1'b1;
            elem_rdata[other*DW +: DW] = $urandom;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int n;
    int idx;
    int r;
    logic [DW-1:0] held;
    logic [AW-1:0] addr;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (elem_reset !== 6'h3f || req_ready !== 1'b1 || resp_valid !== 1'b0 || elem_en !== '0 ||
        resp_err !== 1'b0 || resp_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got rst=%h rdy=%b rv=%b en=%h err=%b data=%h want 3f 1 0 00 0 0",
               elem_reset, req_ready, resp_valid, elem_en, resp_err, resp_data);
    end
    @(posedge clk); #1;
    resetb = 1'b1;

    // Release elements 0 and 1, then read control state back
    send(1'b1, 32'h8000_0000, 32'h0);
    send(1'b1, 32'h8000_0001, 32'h0);
    checks++;
    if (elem_reset !== 6'h3c) begin
      errors++;
      $display("FAIL release: got elem_reset=%h want 3c", elem_reset);
    end
    elem_sleep = 6'b000010;
    send(1'b0, 32'h8000_0001, 32'h0);

    // Memory round trip, then decode errors
    send(1'b1, 32'h0100_0010, 32'hdead_beef);
    send(1'b0, 32'h0100_0010, 32'h0);
    send(1'b0, 32'h8000_0006, 32'h0);
    send(1'b0, 32'h0700_0000, 32'h0);

    // Timeout on element 5 with exact latency
    no_ack_mask = 6'h20;
    fork
      send(1'b0, 32'h0500_0004, 32'h0);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (elem_en !== 6'h20 && n < 2000);
        t0 = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (resp_valid !== 1'b1 && n < 2000);
        checks++;
        if (cyc - t0 != TO || resp_err !== 1'b1) begin
          errors++;
          $display("FAIL timeout_latency: got %0d cycles err=%b want %0d cycles err=1",
                   cyc - t0, resp_err, TO);
        end
      end
    join
    no_ack_mask = '0;

    // Stray acks while idle must not produce anything
    @(posedge clk); #1; stray_ack = 6'h20;
    @(posedge clk); #1; stray_ack = 6'h01;
    @(posedge clk); #1; stray_ack = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || elem_en !== '0) begin
      errors++;
      $display("FAIL stray_ack: got resp_valid=%b elem_en=%h want 0 00", resp_valid, elem_en);
    end

    // Backpressure: response held stable for 10 cycles
    hold_rr = 1'b1;
    fork
      send(1'b0, 32'h0100_0010, 32'h0);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (resp_valid !== 1'b1 && n < 2000);
        held = resp_data;
        repeat (10) begin
          @(negedge clk);
          checks++;
          if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== held) begin
            errors++;
            $display("FAIL backpressure: got rv=%b rdy=%b data=%h want 1 0 %h",
                     resp_valid, req_ready, resp_data, held);
          end
        end
        hold_rr = 1'b0;
      end
    join

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      elem_sleep = NE'($urandom);
      r = $urandom_range(0, 9);
      if (r < 3) begin
        idx = $urandom_range(0, 7);
        addr = {1'b1, 23'($urandom), 8'(idx)};
      end else begin
        idx = $urandom_range(0, 7);
        if ($urandom_range(0, 19) == 0) idx = $urandom_range(8, 127);
        addr = {1'b0, 7'(idx), 24'($urandom_range(0, 15) * 4)};
      end
      no_ack_mask = '0;
      if ($urandom_range(0, 39) == 0) no_ack_mask[$urandom_range(0, NE - 1)] = 1'b1;
      send(1'($urandom), addr, $urandom);
    end
    no_ack_mask = '0;

    // Reset in the middle of a bus cycle aborts it without a response
    no_ack_mask = 6'h20;
    exp_bus_en = 6'h20; exp_bus_we = 1'b0; exp_bus_addr = 24'h000008; exp_bus_wdata = '0;
    issue(1'b0, 32'h0500_0008, 32'h0);
    n = 0;
    while (elem_en !== 6'h20 && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk); #1; resetb = 1'b0;
    @(posedge clk); #1; resetb = 1'b1;
    ref_reset = '1;
    @(negedge clk);
    checks++;
    if (elem_en !== '0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || elem_reset !== 6'h3f) begin
      errors++;
      $display("FAIL reset_in_bus: got en=%h rv=%b rdy=%b rst=%h want 00 0 1 3f",
               elem_en, resp_valid, req_ready, elem_reset);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_resp_after_reset: got resp_valid=%b want 0", resp_valid);
    end
    no_ack_mask = '0;

    // Recovery after reset
    elem_sleep = 6'b000100;
    send(1'b0, 32'h8000_0002, 32'h0);
    send(1'b0, 32'h0100_0010, 32'h0);

    wait_idle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
